// File: rtl/register_file_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between two writeback sources.
// Optional read-after-write bypass of the output stage: define RF_WR_FWD_EN.
module register_file_wr_arbiter #(
    parameter int WORD_W = 32,
    parameter int REG_AW = 5,
    parameter int NREGS  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [REG_AW-1:0] req0_sel,
    input  logic [WORD_W-1:0] req0_dat,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [REG_AW-1:0] req1_sel,
    input  logic [WORD_W-1:0] req1_dat,
    output logic              req1_ready,
    output logic              WEN,
    output logic [REG_AW-1:0] wsel,
    output logic [WORD_W-1:0] wdat,
    output logic [NREGS-1:0]  busy,
    input  logic [REG_AW-1:0] rsel1,
    input  logic [REG_AW-1:0] rsel2,
    input  logic [WORD_W-1:0] rdat1_rf,
    input  logic [WORD_W-1:0] rdat2_rf,
    output logic [WORD_W-1:0] rdat1,
    output logic [WORD_W-1:0] rdat2
);

    logic last_gnt;
    logic xfer0;
    logic xfer1;

    // Grant: single requester wins outright; on contention the one not granted last wins.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!RST && !hold) begin
            req0_ready = req0_valid && (!req1_valid || last_gnt);
            req1_ready = req1_valid && (!req0_valid || !last_gnt);
        end
    end

    assign xfer0 = req0_valid && req0_ready;
    assign xfer1 = req1_valid && req1_ready;

    // Output stage and round-robin pointer; writes to r0 complete but never assert WEN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            WEN      <= 1'b0;
            wsel     <= '0;
            wdat     <= '0;
            last_gnt <= 1'b1;
        end else if (xfer0) begin
            WEN      <= (req0_sel != '0);
            wsel     <= req0_sel;
            wdat     <= req0_dat;
            last_gnt <= 1'b0;
        end else if (xfer1) begin
            WEN      <= (req1_sel != '0);
            wsel     <= req1_sel;
            wdat     <= req1_dat;
            last_gnt <= 1'b1;
        end else begin
            WEN      <= 1'b0;
        end
    end

    // In-flight write marker for hazard logic; WEN implies wsel != 0.
    always_comb begin
        busy = '0;
        if (WEN) begin
            busy[wsel] = 1'b1;
        end
    end

`ifdef RF_WR_FWD_EN
    // Bypass the pending write so reads see it one cycle before it lands.
    always_comb begin
        rdat1 = rdat1_rf;
        rdat2 = rdat2_rf;
        if (WEN && wsel == rsel1 && rsel1 != '0) begin
            rdat1 = wdat;
        end
        if (WEN && wsel == rsel2 && rsel2 != '0) begin
            rdat2 = wdat;
        end
    end
`else
    logic unused_rsel;

    // Pure pass-through; read selects are not needed in this build.
    always_comb begin
        rdat1       = rdat1_rf;
        rdat2       = rdat2_rf;
        unused_rsel = ^{rsel1, rsel2};
    end
`endif

endmodule

// File: tb/tb_register_file_wr_arbiter.sv
// Directed bench for register_file_wr_arbiter.
// Expected read data follows RF_WR_FWD_EN when defined for the build.
module tb_register_file_wr_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        hold;
    logic        req0_valid;
    logic [4:0]  req0_sel;
    logic [31:0] req0_dat;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_sel;
    logic [31:0] req1_dat;
    logic        req1_ready;
    logic        WEN;
    logic [4:0]  wsel;
    logic [31:0] wdat;
    logic [31:0] busy;
    logic [4:0]  rsel1;
    logic [4:0]  rsel2;
    logic [31:0] rdat1_rf;
    logic [31:0] rdat2_rf;
    logic [31:0] rdat1;
    logic [31:0] rdat2;

    int errors = 0;
    int checks = 0;

    register_file_wr_arbiter dut (
        .CLK(CLK), .RST(RST), .hold(hold),
        .req0_valid(req0_valid), .req0_sel(req0_sel),
        .req0_dat(req0_dat), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_sel(req1_sel),
        .req1_dat(req1_dat), .req1_ready(req1_ready),
        .WEN(WEN), .wsel(wsel), .wdat(wdat), .busy(busy),
        .rsel1(rsel1), .rsel2(rsel2),
        .rdat1_rf(rdat1_rf), .rdat2_rf(rdat2_rf),
        .rdat1(rdat1), .rdat2(rdat2)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        req0_valid = 1'b1; req0_sel = 5'd1; req0_dat = 32'h11;
        req1_valid = 1'b1; req1_sel = 5'd2; req1_dat = 32'h22;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rst_ready got=%b want=00", {req0_ready, req1_ready});
        end
        step();
        step();
        checks++;
        if (WEN !== 1'b0 || busy !== 32'h0 || {req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL rst_state got WEN=%b busy=%h rdy=%b want 0/0/00",
                     WEN, busy, {req0_ready, req1_ready});
        end
        RST = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rst_first_grant got=%b want=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd1 || wdat !== 32'h11) begin
            errors++;
            $display("FAIL rst_first_write got %b/%0d/%h want 1/1/11", WEN, wsel, wdat);
        end
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rst_req1_alone got=%b want=01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd2 || wdat !== 32'h22) begin
            errors++;
            $display("FAIL rst_second_write got %b/%0d/%h want 1/2/22", WEN, wsel, wdat);
        end
        step();
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_sel = 5'd5; req0_dat = 32'hDEADBEEF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL single_ready got=%b want=10", {req0_ready, req1_ready});
        end
        step();
        req0_valid = 1'b0;
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'hDEADBEEF || busy !== 32'h20) begin
            errors++;
            $display("FAIL single_out got %b/%0d/%h busy=%h want 1/5/deadbeef busy=20",
                     WEN, wsel, wdat, busy);
        end
        step();
        checks++;
        if (WEN !== 1'b0 || busy !== 32'h0 || wsel !== 5'd5 || wdat !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_idle got %b/%0d/%h busy=%h want 0/5/deadbeef busy=0",
                     WEN, wsel, wdat, busy);
        end
    endtask

    task automatic test_sel0();
        req1_valid = 1'b1; req1_sel = 5'd0; req1_dat = 32'hFFFFFFFF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL sel0_ready got=%b want=01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (WEN !== 1'b0 || busy !== 32'h0 || wsel !== 5'd0) begin
            errors++;
            $display("FAIL sel0_out got WEN=%b wsel=%0d busy=%h want 0/0/0", WEN, wsel, busy);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  esel;
        logic [31:0] edat;
        req0_valid = 1'b1; req0_sel = 5'd3; req0_dat = 32'hA0A0A0A0;
        req1_valid = 1'b1; req1_sel = 5'd4; req1_dat = 32'hB1B1B1B1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL b2b_grant%0d got=%b want=%b", i, {req0_ready, req1_ready},
                         (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            step();
            esel = (i % 2 == 0) ? 5'd3 : 5'd4;
            edat = (i % 2 == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1;
            checks++;
            if (WEN !== 1'b1 || wsel !== esel || wdat !== edat) begin
                errors++;
                $display("FAIL b2b_write%0d got %b/%0d/%h want 1/%0d/%h",
                         i, WEN, wsel, wdat, esel, edat);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        step();
        checks++;
        if (WEN !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got WEN=%b want 0", WEN);
        end
    endtask

    task automatic test_same_sel();
        req0_valid = 1'b1; req0_sel = 5'd9; req0_dat = 32'h111;
        req1_valid = 1'b1; req1_sel = 5'd9; req1_dat = 32'h222;
        step();
        req0_valid = 1'b0;
        checks++;
        if (wdat !== 32'h111 || wsel !== 5'd9) begin
            errors++;
            $display("FAIL same_first got %0d/%h want 9/111", wsel, wdat);
        end
        step();
        req1_valid = 1'b0;
        checks++;
        if (WEN !== 1'b1 || wdat !== 32'h222 || wsel !== 5'd9) begin
            errors++;
            $display("FAIL same_last got %b/%0d/%h want 1/9/222", WEN, wsel, wdat);
        end
        step();
    endtask

    task automatic test_hold();
        req0_valid = 1'b1; req0_sel = 5'd6; req0_dat = 32'h66;
        req1_valid = 1'b1; req1_sel = 5'd7; req1_dat = 32'h77;
        step();
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd6) begin
            errors++;
            $display("FAIL hold_pre got %b/%0d want 1/6", WEN, wsel);
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++;
                $display("FAIL hold_ready%0d got=%b want=00", i, {req0_ready, req1_ready});
            end
            step();
            checks++;
            if (WEN !== 1'b0 || busy !== 32'h0) begin
                errors++;
                $display("FAIL hold_wen%0d got WEN=%b busy=%h want 0/0", i, WEN, busy);
            end
        end
        hold = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got=%b want=01", {req0_ready, req1_ready});
        end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b0;
        checks++;
        if (WEN !== 1'b1 || wsel !== 5'd7 || wdat !== 32'h77) begin
            errors++;
            $display("FAIL hold_resume got %b/%0d/%h want 1/7/77", WEN, wsel, wdat);
        end
        step();
    endtask

    task automatic test_forward();
        logic [31:0] e1;
        req0_valid = 1'b1; req0_sel = 5'd7; req0_dat = 32'h1234;
        step();
        req0_valid = 1'b0;
        rsel1 = 5'd7; rdat1_rf = 32'h0;
        rsel2 = 5'd0; rdat2_rf = 32'h55;
`ifdef RF_WR_FWD_EN
        e1 = 32'h1234;
`else
        e1 = 32'h0;
`endif
        #1;
        checks++;
        if (rdat1 !== e1) begin
            errors++;
            $display("FAIL fwd_hit got=%h want=%h", rdat1, e1);
        end
        checks++;
        if (rdat2 !== 32'h55) begin
            errors++;
            $display("FAIL fwd_r0 got=%h want=55", rdat2);
        end
        rsel1 = 5'd3; rdat1_rf = 32'hAA;
        #1;
        checks++;
        if (rdat1 !== 32'hAA) begin
            errors++;
            $display("FAIL fwd_miss got=%h want=aa", rdat1);
        end
        rsel1 = 5'd7; rdat1_rf = 32'hCC;
        step();
        checks++;
        if (rdat1 !== 32'hCC) begin
            errors++;
            $display("FAIL fwd_stale got=%h want=cc", rdat1);
        end
    endtask

    task automatic test_mid_reset();
        req0_valid = 1'b1; req0_sel = 5'd8; req0_dat = 32'h88;
        step();
        req0_sel = 5'd9; req0_dat = 32'h99;
        RST = 1'b1;
        #1;
        checks++;
        if (WEN !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL mrst_pre got WEN=%b rdy=%b want 1/0", WEN, req0_ready);
        end
        step();
        checks++;
        if (WEN !== 1'b0 || wsel !== 5'd0 || wdat !== 32'h0 || busy !== 32'h0) begin
            errors++;
            $display("FAIL mrst_out got %b/%0d/%h busy=%h want 0/0/0/0", WEN, wsel, wdat, busy);
        end
        req0_valid = 1'b0;
        RST = 1'b0;
        step();
    endtask

    initial begin
        RST = 1'b1; hold = 1'b0;
        req0_valid = 1'b0; req0_sel = '0; req0_dat = '0;
        req1_valid = 1'b0; req1_sel = '0; req1_dat = '0;
        rsel1 = '0; rsel2 = '0; rdat1_rf = '0; rdat2_rf = '0;
        @(negedge CLK);
        test_reset();
        test_single();
        test_sel0();
        test_back_to_back();
        test_same_sel();
        test_hold();
        test_forward();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
